// File: rtl/adc_ltc2308_responder.sv
// LTC2308-compatible SPI responder: serves 12-bit samples from a parallel bus over CONVST/SCLK/DIN/DOUT.
// Optional macro ADC_RESP_BIPOLAR_EN: with UNI=0 at snapshot the sample MSB is inverted (two's complement).
module adc_ltc2308_responder #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6,
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     adc_convst,
  input  logic                     adc_sclk,
  input  logic                     adc_din,
  output logic                     adc_dout,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     busy,
  output logic [CFG_W-1:0]         cfg_word,
  output logic                     cfg_valid
);

  localparam int CNT_W  = $clog2(CONV_CYCLES);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int CFGC_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [CFGC_W-1:0] CFG_FULL  = CFGC_W'(CFG_W);
  localparam logic [CFG_W-1:0]  CFG_RESET = CFG_W'(6'b100010);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT
  } state_t;

  state_t              state_reg;
  logic [2:0]          sync_reg [SYNC_STAGES];
  logic [1:0]          prev_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic [CFGC_W-1:0]   cfg_cnt_reg;
  logic [CFG_W-1:0]    cfg_shift_reg;
  logic [CFG_W-1:0]    cfg_word_reg;
  logic                cfg_valid_reg;
  logic [DATA_W-1:0]   sample_reg;
  logic                adc_dout_reg;
  logic                busy_reg;

  logic [DATA_W-1:0]   ch_sample [NUM_CH];
  logic [2:0]          sync_last;
  logic                convst_s;
  logic                sclk_s;
  logic                din_s;
  logic                convst_rise;
  logic                sclk_rise;
  logic                sclk_fall;
  logic [2:0]          cfg_ch;
  logic [DATA_W-1:0]   raw_sample;
  logic [DATA_W-1:0]   snap_sample;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_sample[gi] = ch_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Bit order of the synchronizer word: {convst, sclk, din}
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= 3'b000;
      end
      prev_reg <= 2'b00;
    end else begin
      sync_reg[0] <= {adc_convst, adc_sclk, adc_din};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= {convst_s, sclk_s};
    end
  end

  assign sync_last   = sync_reg[SYNC_STAGES-1];
  assign convst_s    = sync_last[2];
  assign sclk_s      = sync_last[1];
  assign din_s       = sync_last[0];
  assign convst_rise = convst_s & ~prev_reg[1];
  assign sclk_rise   = sclk_s & ~prev_reg[0];
  assign sclk_fall   = ~sclk_s & prev_reg[0];

  // Channel index is {S1, S0, O/S}; config word layout is {S/D, O/S, S1, S0, UNI, SLP}
  assign cfg_ch = {cfg_word_reg[3], cfg_word_reg[2], cfg_word_reg[4]};

  always_comb begin
    raw_sample = '0;
    if (int'(cfg_ch) < NUM_CH) begin
      raw_sample = ch_sample[cfg_ch];
    end
  end

`ifdef ADC_RESP_BIPOLAR_EN
  assign snap_sample = {raw_sample[DATA_W-1] ^ ~cfg_word_reg[1], raw_sample[DATA_W-2:0]};
`else
  assign snap_sample = raw_sample;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      cfg_cnt_reg   <= '0;
      cfg_shift_reg <= '0;
      cfg_word_reg  <= CFG_RESET;
      cfg_valid_reg <= 1'b0;
      sample_reg    <= '0;
      adc_dout_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      cfg_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          adc_dout_reg <= 1'b0;
          if (convst_rise) begin
            sample_reg <= snap_sample;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= CONV;
          end
        end
        CONV: begin
          if (cnt_reg == CONV_LAST) begin
            busy_reg      <= 1'b0;
            adc_dout_reg  <= sample_reg[DATA_W-1];
            bit_cnt_reg   <= '0;
            cfg_cnt_reg   <= '0;
            cfg_shift_reg <= '0;
            state_reg     <= SHIFT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SHIFT: begin
          // A new CONVST aborts the read; any SCLK edge on the same cycle is dropped
          if (convst_rise) begin
            sample_reg   <= snap_sample;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            adc_dout_reg <= 1'b0;
            state_reg    <= CONV;
          end else if (sclk_rise) begin
            if (cfg_cnt_reg < CFG_FULL) begin
              cfg_shift_reg <= {cfg_shift_reg[CFG_W-2:0], din_s};
              cfg_cnt_reg   <= cfg_cnt_reg + 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt_reg == BIT_LAST) begin
              adc_dout_reg <= 1'b0;
              state_reg    <= IDLE;
              if (cfg_cnt_reg == CFG_FULL) begin
                cfg_word_reg  <= cfg_shift_reg;
                cfg_valid_reg <= 1'b1;
              end
            end else begin
              bit_cnt_reg  <= bit_cnt_reg + 1'b1;
              sample_reg   <= {sample_reg[DATA_W-2:0], 1'b0};
              adc_dout_reg <= sample_reg[DATA_W-2];
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign adc_dout  = adc_dout_reg;
  assign busy      = busy_reg;
  assign cfg_word  = cfg_word_reg;
  assign cfg_valid = cfg_valid_reg;

endmodule

// File: tb/tb_adc_ltc2308_responder.sv
// Scoreboard bench for adc_ltc2308_responder: a host model drives CONVST/SCLK/DIN and checks every read.
// Expectations honour ADC_RESP_BIPOLAR_EN when it is defined for the build.
module tb_adc_ltc2308_responder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         adc_convst = 1'b0;
  logic         adc_sclk = 1'b0;
  logic         adc_din = 1'b0;
  logic         adc_dout;
  logic [95:0]  ch_data;
  logic         busy;
  logic [5:0]   cfg_word;
  logic         cfg_valid;

  logic [11:0]  ch_val [8];
  logic [11:0]  exp_q [$];
  logic [5:0]   model_cfg;
  int           checks = 0;
  int           errors = 0;
  int           cfg_valid_cnt = 0;
  int           read_no = 0;

  always #10 clk = ~clk;

  adc_ltc2308_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adc_convst (adc_convst),
    .adc_sclk   (adc_sclk),
    .adc_din    (adc_din),
    .adc_dout   (adc_dout),
    .ch_data    (ch_data),
    .busy       (busy),
    .cfg_word   (cfg_word),
    .cfg_valid  (cfg_valid)
  );

  always_comb begin
    ch_data = '0;
    for (int i = 0; i < 8; i++) begin
      ch_data[i*12 +: 12] = ch_val[i];
    end
  end

  always @(negedge clk) begin
    if (cfg_valid === 1'b1) cfg_valid_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_sample(input logic [5:0] cfg);
    logic [2:0]  ch;
    logic [11:0] v;
    ch = {cfg[3], cfg[2], cfg[4]};
    v  = ch_val[ch];
`ifdef ADC_RESP_BIPOLAR_EN
    if (!cfg[1]) v[11] = ~v[11];
`endif
    return v;
  endfunction

  // Push the expected sample, raise CONVST and measure the busy window.
  task automatic start_conv(input logic ignore_test);
    int waited;
    int n;
    exp_q.push_back(model_sample(model_cfg));
    @(negedge clk) adc_convst = 1'b1;
    waited = 0;
    while (busy !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("busy_rise", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      if (n == 2) adc_convst = 1'b0;
      if (ignore_test && n == 40) begin
        ch_val[1]  = 12'h777;
        adc_convst = 1'b1;
      end
      if (ignore_test && n == 46) adc_convst = 1'b0;
      @(negedge clk);
      n++;
    end
    adc_convst = 1'b0;
    check("busy_len", n, 80);
  endtask

  task automatic host_read(input logic [5:0] din_word, input int nbits, output logic [11:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      adc_din = (i < 6) ? din_word[5-i] : 1'b0;
      repeat (6) @(negedge clk);
      got[11-i] = adc_dout;
      adc_sclk = 1'b1;
      repeat (6) @(negedge clk);
      adc_sclk = 1'b0;
    end
    adc_din = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop_exp(output logic [11:0] exp);
    exp = '0;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
    end
  endtask

  task automatic do_read(input logic [5:0] din_word);
    logic [11:0] got;
    logic [11:0] exp;
    int          cv0;
    cv0 = cfg_valid_cnt;
    host_read(din_word, 12, got);
    pop_exp(exp);
    read_no++;
    $display("read %0d data=%03h exp=%03h din=%06b", read_no, got, exp, din_word);
    check("read_data", got, exp);
    model_cfg = din_word;
    check("cfg_valid_cnt", cfg_valid_cnt - cv0, 1);
    check("cfg_word", cfg_word, model_cfg);
    check("dout_idle", adc_dout, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [11:0] got;
    logic [11:0] exp;
    int          cv0;
    for (int i = 0; i < 8; i++) ch_val[i] = 12'(i * 12'h111);
    ch_val[0] = 12'hA5C;
    ch_val[1] = 12'h123;
    model_cfg = 6'b100010;

    repeat (5) @(negedge clk);
    check("rst_dout", adc_dout, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_word", cfg_word, 6'b100010);
    check("rst_cfg_valid", cfg_valid, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Read 1: CH0 straight, config in effect untouched until the read ends
    start_conv(1'b0);
    check("cfg_hold", cfg_word, 6'b100010);
    do_read(6'b000000);

    // Read 2: CH0 with UNI=0
    ch_val[0] = 12'h800;
    start_conv(1'b0);
    do_read(6'b110010);

    // Read 3: CH1 selected; a CONVST rise mid-conversion is ignored
    start_conv(1'b1);
    ch_val[1] = 12'h123;
    do_read(6'b100010);

    // Read 4: aborted after five falling edges, then a fresh snapshot
    ch_val[0] = 12'h3C3;
    start_conv(1'b0);
    host_read(6'b111111, 5, got);
    pop_exp(exp);
    $display("read abort bits=%02h exp=%02h", got[11:7], exp[11:7]);
    check("abort_bits", got[11:7], exp[11:7]);
    cv0 = cfg_valid_cnt;
    ch_val[0] = 12'h5A1;
    start_conv(1'b0);
    check("abort_no_valid", cfg_valid_cnt - cv0, 0);
    check("abort_cfg_word", cfg_word, 6'b100010);
    do_read(6'b110010);

    // Read 5: reset asserted mid-SHIFT
    start_conv(1'b0);
    host_read(6'b101010, 3, got);
    pop_exp(exp);
    $display("read reset bits=%01h exp=%01h", got[11:9], exp[11:9]);
    check("pre_rst_bits", got[11:9], exp[11:9]);
    check("pre_rst_dout", adc_dout, exp[8]);
    cv0 = cfg_valid_cnt;
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("midrst_dout", adc_dout, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cfg_word", cfg_word, 6'b100010);
    model_cfg = 6'b100010;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_valid", cfg_valid_cnt - cv0, 0);
    check("post_rst_busy", busy, 0);

    // Read 6: recovery after reset
    start_conv(1'b0);
    do_read(6'b100010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
